// File: rtl/cache_bus_responder.sv
// Memory-side responder for the data cache-bus. Stores are posted into a
// FIFO write buffer and drained to the memory port in order. Loads wait
// behind any buffered stores, then issue one read. Every accepted request
// gets exactly one response pulse, except loads killed by a pipeline flush.
module cache_bus_responder #(
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        flush_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        wb_empty_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT_WB,
        LD_REQ,
        LD_DATA,
        LD_KILL
    } state_t;

    state_t state;

    // Write buffer storage and control
    logic [29:0]   wb_addr [WB_DEPTH];
    logic [3:0]    wb_strb [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    // Captured load attributes
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_signed;

    logic wb_full;
    logic misaligned;
    logic req_fire;
    logic mis_fire;
    logic st_fire;
    logic ld_fire;
    logic wr_req;
    logic ld_req;
    logic push;
    logic pop;

    // Half needs 2-byte alignment, word (and size 3) needs 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = a[0];
            default: bad = (a != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            2'd0:    s = 4'b0001 << a;
            2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Replicate the LSB-aligned store data across every lane it may land on.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] d;
        case (size)
            2'd0:    d = {4{w[7:0]}};
            2'd1:    d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    // Pull the addressed byte/half down to bit 0 and zero- or sign-extend it.
    function automatic logic [31:0] load_format(input logic [1:0] size, input logic sgn,
                                                input logic [1:0] a, input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {a, 3'b000};
        case (size)
            2'd0:    r = {{24{sgn & sh[7]}}, sh[7:0]};
            2'd1:    r = {{16{sgn & sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    assign wb_full    = (count == CW'(WB_DEPTH));
    assign misaligned = is_misaligned(req_size_i, req_addr_i[1:0]);

    // A full buffer refuses stores even if the head drains this cycle.
    assign req_ready_o = rst_n & (state == IDLE) & ~flush_i & (~req_we_i | ~wb_full | misaligned);

    assign req_fire = req_valid_i & req_ready_o;
    assign mis_fire = req_fire & misaligned;
    assign st_fire  = req_fire & req_we_i & ~misaligned;
    assign ld_fire  = req_fire & ~req_we_i & ~misaligned;

    // The head stays presented while the FSM is in IDLE/LD_WAIT_WB; nothing
    // else can change head until it is popped, so the request holds stable.
    assign wr_req = (count != '0) & ((state == IDLE) | (state == LD_WAIT_WB));
    assign ld_req = (state == LD_REQ);
    assign push   = st_fire;
    assign pop    = wr_req & mem_gnt_i;

    assign wb_empty_o = (count == '0) & ~wr_req;

    // Memory port mux: buffered write, load read, or quiet zeros.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wstrb_o = '0;
        mem_wdata_o = '0;
        if (wr_req) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {wb_addr[head], 2'b00};
            mem_wstrb_o = wb_strb[head];
            mem_wdata_o = wb_data[head];
        end else if (ld_req) begin
            mem_req_o  = 1'b1;
            mem_addr_o = {ld_addr[31:2], 2'b00};
        end
    end

    // Write buffer pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Write buffer entry storage
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[tail] <= req_addr_i[31:2];
            wb_strb[tail] <= store_strb(req_size_i, req_addr_i[1:0]);
            wb_data[tail] <= store_data(req_size_i, req_wdata_i);
        end
    end

    // Load attributes captured at acceptance
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            ld_addr   <= req_addr_i;
            ld_size   <= req_size_i;
            ld_signed <= req_signed_i;
        end
    end

    // Load sequencing FSM with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            if (mis_fire) begin
                resp_valid_o <= 1'b1;
                resp_err_o   <= 1'b1;
            end
            if (st_fire) begin
                resp_valid_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ld_fire) state <= (count == '0) ? LD_REQ : LD_WAIT_WB;
                end
                LD_WAIT_WB: begin
                    if (flush_i)             state <= IDLE;
                    else if (count == '0)    state <= LD_REQ;
                end
                LD_REQ: begin
                    if (mem_gnt_i)    state <= flush_i ? LD_KILL : LD_DATA;
                    else if (flush_i) state <= IDLE;
                end
                LD_DATA: begin
                    // Data arriving in the flush cycle is consumed and dropped.
                    if (mem_rvalid_i) begin
                        if (!flush_i) begin
                            resp_valid_o <= 1'b1;
                            resp_rdata_o <= load_format(ld_size, ld_signed, ld_addr[1:0], mem_rdata_i);
                        end
                        state <= IDLE;
                    end else if (flush_i) begin
                        state <= LD_KILL;
                    end
                end
                LD_KILL: begin
                    if (mem_rvalid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bus_responder.sv
// Directed bench for cache_bus_responder: a table of single transactions
// followed by hand-written multi-cycle sequences (buffer full, load behind
// stores, flush, reset mid-transaction).
module tb_cache_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        wb_empty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_bus_responder #(.WB_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .flush_i      (flush),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .wb_empty_o   (wb_empty),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wstrb_o  (mem_wstrb),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] data;      // store data, or memory read word for loads
        logic        err;
        logic [31:0] exp_addr;  // expected memory word address
        logic [3:0]  exp_strb;  // expected write strobes (stores)
        logic [31:0] exp_word;  // expected mem_wdata (store) or resp_rdata (load)
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // One accepted request, held for a single cycle.
    task automatic issue(input string name, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        drive_req(we, size, sgn, addr, wdata);
        mid();
        chk({name, "_ready"}, req_ready, 1);
        nxt();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h1234_56A5, 1'b0, 32'h0000_1000, 4'b0010, 32'hA5A5_A5A5};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'hFFFF_BEEF, 1'b0, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h0000_1000, 32'h0000_1234, 1'b0, 32'h0000_1000, 4'b0011, 32'h1234_1234};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_007E, 1'b0, 32'h0000_1000, 4'b1000, 32'h7E7E_7E7E};
        vecs[5]  = '{1'b1, 2'd3, 1'b0, 32'h0000_1004, 32'h0102_0304, 1'b0, 32'h0000_1004, 4'b1111, 32'h0102_0304};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h1122_3344, 1'b0, 32'h0000_2000, 4'b0000, 32'h0000_0033};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h0000_2002, 32'h00F0_0000, 1'b0, 32'h0000_2000, 4'b0000, 32'hFFFF_FFF0};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h8001_1234, 1'b0, 32'h0000_2000, 4'b0000, 32'hFFFF_8001};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h0000_2000, 32'hFFFF_9ABC, 1'b0, 32'h0000_2000, 4'b0000, 32'h0000_9ABC};
        vecs[10] = '{1'b0, 2'd2, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 1'b0, 32'h0000_2004, 4'b0000, 32'hCAFE_F00D};
        vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h0000_2000, 32'h0000_7FFF, 1'b0, 32'h0000_2000, 4'b0000, 32'h0000_7FFF};
        vecs[12] = '{1'b0, 2'd1, 1'b0, 32'h0000_3001, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h0000_3002, 32'h5555_AAAA, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h0000_3003, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0000, 32'h0000_0000};
        vecs[15] = '{1'b0, 2'd0, 1'b0, 32'h0000_2003, 32'h80FF_FFFF, 1'b0, 32'h0000_2000, 4'b0000, 32'h0000_0080};

        quiet();
        rst_n = 1'b0;

        // Reset state
        mid();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_wb_empty", wb_empty, 1);
        chk("rst_req_ready", req_ready, 0);
        nxt();
        nxt();
        rst_n = 1'b1;
        mid();
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_resp_rdata", resp_rdata, 0);
        nxt();

        // Table of single transactions with an immediately granting memory
        for (int i = 0; i < 16; i++) begin
            issue($sformatf("v%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].data);
            if (vecs[i].err) begin
                mid();
                chk($sformatf("v%0d_resp_valid", i), resp_valid, 1);
                chk($sformatf("v%0d_resp_err", i), resp_err, 1);
                chk($sformatf("v%0d_resp_rdata", i), resp_rdata, 0);
                chk($sformatf("v%0d_no_mem_req", i), mem_req, 0);
                chk($sformatf("v%0d_wb_empty", i), wb_empty, 1);
                nxt();
            end else if (vecs[i].we) begin
                mem_gnt = 1'b1;
                mid();
                chk($sformatf("v%0d_resp_valid", i), resp_valid, 1);
                chk($sformatf("v%0d_resp_err", i), resp_err, 0);
                chk($sformatf("v%0d_resp_rdata", i), resp_rdata, 0);
                chk($sformatf("v%0d_mem_req", i), mem_req, 1);
                chk($sformatf("v%0d_mem_we", i), mem_we, 1);
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
                chk($sformatf("v%0d_mem_wstrb", i), mem_wstrb, vecs[i].exp_strb);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_word);
                nxt();
                mem_gnt = 1'b0;
                mid();
                chk($sformatf("v%0d_mem_req_done", i), mem_req, 0);
                nxt();
                mid();
                chk($sformatf("v%0d_wb_empty", i), wb_empty, 1);
                nxt();
            end else begin
                mem_gnt = 1'b1;
                mid();
                chk($sformatf("v%0d_mem_req", i), mem_req, 1);
                chk($sformatf("v%0d_mem_we", i), mem_we, 0);
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
                chk($sformatf("v%0d_mem_wstrb", i), mem_wstrb, 0);
                nxt();
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b1;
                mem_rdata  = vecs[i].data;
                mid();
                chk($sformatf("v%0d_early_resp", i), resp_valid, 0);
                nxt();
                mem_rvalid = 1'b0;
                mid();
                chk($sformatf("v%0d_resp_valid", i), resp_valid, 1);
                chk($sformatf("v%0d_resp_err", i), resp_err, 0);
                chk($sformatf("v%0d_resp_rdata", i), resp_rdata, vecs[i].exp_word);
                nxt();
            end
        end

        // Five byte stores into a 4-deep buffer with the bus stalled
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b1, 2'd0, 1'b0, 32'h0000_4000 + 32'(i), 32'(i + 1));
            mid();
            chk($sformatf("full_ready%0d", i), req_ready, (i < 4) ? 32'd1 : 32'd0);
            nxt();
        end
        mid();
        chk("full_ready_hold", req_ready, 0);
        chk("full_mem_req_hold", mem_req, 1);
        chk("full_mem_addr_hold", mem_addr, 32'h0000_4000);
        chk("full_strb_hold", mem_wstrb, 4'b0001);
        chk("full_wb_empty", wb_empty, 0);
        nxt();
        mem_gnt = 1'b1;
        mid();
        chk("drain0_ready", req_ready, 0);
        chk("drain0_strb", mem_wstrb, 4'b0001);
        chk("drain0_wdata", mem_wdata, 32'h0101_0101);
        nxt();
        mid();
        chk("drain1_ready", req_ready, 1);
        chk("drain1_strb", mem_wstrb, 4'b0010);
        chk("drain1_wdata", mem_wdata, 32'h0202_0202);
        nxt();
        req_valid = 1'b0;
        mid();
        chk("drain2_resp5", resp_valid, 1);
        chk("drain2_strb", mem_wstrb, 4'b0100);
        chk("drain2_wdata", mem_wdata, 32'h0303_0303);
        nxt();
        mid();
        chk("drain3_strb", mem_wstrb, 4'b1000);
        chk("drain3_wdata", mem_wdata, 32'h0404_0404);
        nxt();
        mid();
        chk("drain4_addr", mem_addr, 32'h0000_4004);
        chk("drain4_strb", mem_wstrb, 4'b0001);
        chk("drain4_wdata", mem_wdata, 32'h0505_0505);
        nxt();
        mem_gnt = 1'b0;
        mid();
        chk("drain_done_req", mem_req, 0);
        chk("drain_done_empty", wb_empty, 1);
        nxt();

        // Signed byte load serialised behind two buffered stores
        issue("lbw_st0", 1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'h1111_1111);
        issue("lbw_st1", 1'b1, 2'd2, 1'b0, 32'h0000_5004, 32'h2222_2222);
        issue("lbw_ld", 1'b0, 2'd0, 1'b1, 32'h0000_2003, 32'h0);
        mid();
        chk("lbw_w0_we", mem_we, 1);
        chk("lbw_w0_addr", mem_addr, 32'h0000_5000);
        nxt();
        mem_gnt = 1'b1;
        mid();
        chk("lbw_w1_we", mem_we, 1);
        chk("lbw_w1_addr", mem_addr, 32'h0000_5000);
        nxt();
        mid();
        chk("lbw_w2_we", mem_we, 1);
        chk("lbw_w2_addr", mem_addr, 32'h0000_5004);
        nxt();
        mem_gnt = 1'b0;
        mid();
        chk("lbw_gap_req", mem_req, 0);
        chk("lbw_gap_empty", wb_empty, 1);
        nxt();
        mem_gnt = 1'b1;
        mid();
        chk("lbw_ld_req", mem_req, 1);
        chk("lbw_ld_we", mem_we, 0);
        chk("lbw_ld_addr", mem_addr, 32'h0000_2000);
        nxt();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_FFFF;
        mid();
        nxt();
        mem_rvalid = 1'b0;
        mid();
        chk("lbw_resp_valid", resp_valid, 1);
        chk("lbw_resp_rdata", resp_rdata, 32'hFFFF_FF80);
        nxt();

        // Flush in LD_DATA, late stale data, then a clean load
        issue("fl_ld", 1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0);
        mem_gnt = 1'b1;
        mid();
        chk("fl_mem_req", mem_req, 1);
        nxt();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        mid();
        chk("fl_ready_blocked", req_ready, 0);
        nxt();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mid();
            chk($sformatf("fl_kill%0d_resp", k), resp_valid, 0);
            chk($sformatf("fl_kill%0d_ready", k), req_ready, 0);
            chk($sformatf("fl_kill%0d_req", k), mem_req, 0);
            nxt();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        mid();
        nxt();
        mem_rvalid = 1'b0;
        mid();
        chk("fl_no_resp", resp_valid, 0);
        chk("fl_ready_back", req_ready, 1);
        nxt();
        issue("fl_ld2", 1'b0, 2'd2, 1'b0, 32'h0000_6004, 32'h0);
        mem_gnt = 1'b1;
        mid();
        chk("fl_ld2_addr", mem_addr, 32'h0000_6004);
        nxt();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h600D_600D;
        mid();
        nxt();
        mem_rvalid = 1'b0;
        mid();
        chk("fl_ld2_resp_valid", resp_valid, 1);
        chk("fl_ld2_rdata", resp_rdata, 32'h600D_600D);
        nxt();

        // Flush in LD_REQ before grant
        issue("flq_ld", 1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0);
        flush = 1'b1;
        mid();
        chk("flq_mem_req", mem_req, 1);
        nxt();
        flush = 1'b0;
        mid();
        chk("flq_req_gone", mem_req, 0);
        chk("flq_ready", req_ready, 1);
        chk("flq_no_resp", resp_valid, 0);
        nxt();

        // Reset while a load waits behind two buffered stores
        issue("rm_st0", 1'b1, 2'd2, 1'b0, 32'h0000_8000, 32'hAAAA_0000);
        issue("rm_st1", 1'b1, 2'd2, 1'b0, 32'h0000_8004, 32'hBBBB_0000);
        issue("rm_ld", 1'b0, 2'd2, 1'b0, 32'h0000_8100, 32'h0);
        mid();
        chk("rm_mem_req_before", mem_req, 1);
        chk("rm_wb_empty_before", wb_empty, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_mem_req_async", mem_req, 0);
        chk("rm_wb_empty_async", wb_empty, 1);
        nxt();
        rst_n = 1'b1;
        mid();
        chk("rm_ready_after", req_ready, 1);
        chk("rm_wb_empty_after", wb_empty, 1);
        chk("rm_mem_req_after", mem_req, 0);
        nxt();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        mid();
        nxt();
        mem_rvalid = 1'b0;
        mid();
        chk("rm_stray_rvalid", resp_valid, 0);
        chk("rm_stray_ready", req_ready, 1);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
